// File: rtl/serial_rx_pkg.sv
// Shared definitions for the framed serial receive path: FSM state encoding
// and the default data width used by both the transmit and receive sides.
package serial_rx_pkg;

  localparam int SERIAL_RX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

endpackage : serial_rx_pkg

// File: rtl/serial_frame_receiver_if.sv
// Bundle of the receiver's line-side inputs and word-side outputs.
// master: the side driving the serial line (transmitter / testbench).
// slave:  the receiver itself.
interface serial_rx_if #(
  parameter int WIDTH = serial_rx_pkg::SERIAL_RX_WIDTH
);

  logic             sample_en;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             parity_err;
  logic             busy;

  modport master (
    output sample_en,
    output serial_in,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  sample_en,
    input  serial_in,
    output data_out,
    output data_valid,
    output frame_err,
    output parity_err,
    output busy
  );

endinterface : serial_rx_if

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register. New bits enter at the LSB, so after
// WIDTH shifts the first bit received sits in the MSB.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  // Left shift on enable; cleared by reset so a partial frame is discarded.
  // NOTE: the shift register is reset (not left uninitialised like a RAM)
  // because its reset value is architecturally visible after a mid-frame reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (shift_en_i) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      data_q <= {data_q[WIDTH-2:0], bit_i};
    end
  end

  assign data_o = data_q;

endmodule : sipo_shift_reg

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start bit 0, WIDTH data bits MSB-first, optional
// even-parity bit, stop bit 1. Presents each good word with a one-cycle
// data_valid strobe; bad stop bits and parity mismatches pulse error flags.
// Optional feature macro: SERIAL_RX_PARITY_EN (adds the parity bit/check).
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = SERIAL_RX_WIDTH
) (
  input logic        clk,
  input logic        rst,
  serial_rx_if.slave rx
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             shift_en;
  logic [WIDTH-1:0] shift_word;
`ifdef SERIAL_RX_PARITY_EN
  logic             mis_q, mis_d;
  logic             perr_q, perr_d;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .bit_i      (rx.serial_in),
    .data_o     (shift_word)
  );

  // State, counter, held word and registered pulse flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      mis_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      mis_q   <= mis_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state and pulse decode; everything holds and pulses drop while
  // sample_en is low.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    shift_en = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    mis_d    = mis_q;
    perr_d   = 1'b0;
`endif
    if (rx.sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!rx.serial_in) begin
            state_d = ST_DATA;
            cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
            mis_d   = 1'b0;
`endif
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        ST_PARITY: begin
          // Even parity: data bits XOR parity bit must be zero.
          mis_d   = rx.serial_in ^ (^shift_word);
          state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          // A low stop bit is a framing error, never a new start bit.
          state_d = ST_IDLE;
          if (!rx.serial_in) begin
            ferr_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          end else if (mis_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shift_word;
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = (state_q != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign rx.parity_err = perr_q;
`else
  assign rx.parity_err = 1'b0;
`endif

endmodule : serial_frame_receiver

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receives the framed serial bitstream produced by the parallel-in serial-out transmit shifter and reassembles it into parallel words. It sits directly downstream of the PISO stage: it samples one bit per enabled clock, detects a start bit, shifts in WIDTH data bits MSB-first, checks the stop bit, and presents the word with a one-cycle valid strobe. Framing errors and, optionally, parity errors are flagged per frame.

## Interface
- WIDTH, 4, number of data bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- sample_en  input  1  bit-sample enable; when low, all state holds
- serial_in  input  1  serial line; idles high
- data_out  output  WIDTH  last correctly framed word, MSB = first data bit received
- data_valid  output  1  one-cycle pulse: data_out just updated
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- parity_err  output  1  one-cycle pulse: parity mismatch (always 0 without SERIAL_RX_PARITY_EN)
- busy  output  1  high in any state other than IDLE

## Operation
- Frame on the line: start bit 0, WIDTH data bits MSB-first, optional even-parity bit, stop bit 1.
- FSM states: IDLE, DATA, PARITY (only with macro), STOP.
- All transitions and sampling occur only on clk edges with sample_en=1. With sample_en=0, state, bit counter, and shift register hold, and all pulses deassert.
- IDLE: serial_in=0 -> DATA, bit counter cleared; serial_in=1 -> stay.
- DATA: shift serial_in into LSB of the shift register (left shift); counter increments; after WIDTH-th bit -> PARITY if enabled, else STOP. Counter width is clog2(WIDTH); no wrap is possible because exit occurs at count WIDTH-1.
- PARITY: compare serial_in against XOR of received data bits (even parity: XOR of data and parity bits must be 0); record mismatch; -> STOP.
- STOP, serial_in=1: data_out <= shift register, data_valid pulse; parity_err pulse instead of data_valid if mismatch recorded (data_out not updated on parity error). -> IDLE.
- STOP, serial_in=0: frame_err pulse, data_out unchanged, -> IDLE. A low stop bit is not treated as a start bit.
- frame_err takes priority: a frame with both bad stop and bad parity pulses only frame_err.
- Reset (any time, including mid-frame): state IDLE, counter 0, shift register 0, data_out 0, data_valid/frame_err/parity_err/busy 0. Partial frame is discarded.

## Timing
- data_valid/frame_err/parity_err are registered: high in the cycle after the enabled edge that samples the stop bit, for exactly one cycle.
- Latency: start-bit edge to data_valid = WIDTH+2 enabled edges (WIDTH+3 with parity).
- Back-to-back frames: the enabled sample immediately following the stop bit may be the next start bit; no idle gap is required.
- busy asserts the cycle after start detection and deasserts the cycle after the stop sample.
- data_out holds its value between valid pulses.

## Configuration
- SERIAL_RX_PARITY_EN defined: PARITY state, parity checker, and parity_err logic compiled in; frame length WIDTH+3 bits.
- Undefined: no PARITY state; STOP follows the last data bit; parity_err tied to 0; frame length WIDTH+2 bits.

## Structure
- Package serial_rx_pkg: FSM state enum (IDLE, DATA, PARITY, STOP) and the default data-width constant (4), shared with the transmit side.
- One sub-module, sipo_shift_reg: WIDTH-bit shift register with shift enable and async active-low clear. The FSM, counter, and flag registers stay in the top.

## Test plan
- Reset mid-frame: drive start plus 2 data bits, pulse rst low -> all outputs 0, busy 0, next full frame received correctly.
- Nominal, no parity: line 1,0,1,0,1,1,1 (start, 1011, stop) -> data_out=4'hB, single data_valid pulse 6 enabled edges after the start sample edge.
- Back-to-back: frames 4'hA then 4'h5 with no gap -> two data_valid pulses 6 cycles apart, data_out 4'hA then 4'h5.
- Framing error: start, 1100, stop=0 -> frame_err pulse, no data_valid, data_out keeps previous value; the following frame decodes.
- sample_en gaps: 4'h9 frame with sample_en low every other cycle -> data_out=4'h9, same result as with continuous enable.
- With SERIAL_RX_PARITY_EN: 4'h7 plus parity 1 -> data_valid; 4'h7 plus parity 0 -> parity_err only, data_out unchanged.
